// File: rtl/instr_encoder_if.sv
// Handshake bundle between a macro-op producer and the instruction encoder.
// The request channel carries one macro-op; the output channel streams the
// resulting decoder instruction words together with encoder status.
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  // Request channel (producer -> encoder)
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [5:0]       req_arg;
  logic [11:0]      req_imm;
  logic             req_wide;

  // Instruction word channel (encoder -> decoder)
  logic             out_valid;
  logic             out_ready;
  logic [8:0]       out_instr;

  // Status
  logic             prep_mode;
  logic             err;
  logic [CNT_W-1:0] instr_count;

  // Producer / consumer side, as seen from outside the encoder.
  modport master (
    output req_valid, req_op, req_arg, req_imm, req_wide, out_ready,
    input  req_ready, out_valid, out_instr, prep_mode, err, instr_count
  );

  // Encoder side.
  modport slave (
    input  req_valid, req_op, req_arg, req_imm, req_wide, out_ready,
    output req_ready, out_valid, out_instr, prep_mode, err, instr_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Macro-op to instruction-word encoder.
// Each accepted macro-op expands into one to three 9-bit decoder words:
// single-word ops emit only the op word; prep-class ops first load their
// immediate through a PREP word (and a PSFT word when 12 bits are needed).
// Words are presented with a valid/ready handshake and held while stalled.
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           reset,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    PSFT = 2'd2,
    OP   = 2'd3
  } stateT;

  // Macro-op codes
  localparam logic [3:0] OP_INC  = 4'd0;
  localparam logic [3:0] OP_DEC  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_XORR = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_ANDI = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;
  localparam logic [3:0] OP_SAVE = 4'd10;

  // Decoder opcodes used by the immediate-loading words
  localparam logic [2:0] DEC_PREP = 3'b000;
  localparam logic [2:0] DEC_PSFT = 3'b101;

  // Registered state
  stateT            stateQ;
  logic [3:0]       capOp;
  logic [5:0]       capArg;
  logic [11:0]      capImm;
  logic             capWide;
  logic             outValidQ;
  logic [8:0]       outInstrQ;
  logic             prepModeQ;
  logic             errQ;
  logic [CNT_W-1:0] instrCountQ;

  // Next-state values
  stateT            stateD;
  logic [3:0]       capOpD;
  logic [5:0]       capArgD;
  logic [11:0]      capImmD;
  logic             capWideD;
  logic             outValidD;
  logic [8:0]       outInstrD;
  logic             prepModeD;
  logic             errD;
  logic [CNT_W-1:0] instrCountD;

  logic             handoff;

  function automatic logic isSingleOp(input logic [3:0] op);
    return op <= OP_SRL;
  endfunction

  function automatic logic isPrepOp(input logic [3:0] op);
    return (op >= OP_ANDI) && (op <= OP_SAVE);
  endfunction

  // Final instruction word of a macro-op. INC and DEC share the decoder's
  // increment opcode and select direction through the lastBit.
  function automatic logic [8:0] opWord(input logic [3:0] op, input logic [5:0] arg);
    logic [8:0] word;
    word = '0;
    unique case (op)
      OP_INC:  word = {3'b001, arg[5:1], 1'b1};
      OP_DEC:  word = {3'b001, arg[5:1], 1'b0};
      OP_XOR:  word = {3'b010, arg};
      OP_XORR: word = {3'b011, arg};
      OP_SLL:  word = {3'b100, arg};
      OP_SRL:  word = {3'b101, arg};
      OP_ANDI: word = {3'b000, arg};
      OP_BEQ:  word = {3'b001, arg};
      OP_LW:   word = {3'b010, arg};
      OP_SW:   word = {3'b011, arg};
      OP_SAVE: word = {3'b100, arg};
      default: word = '0;
    endcase
    return word;
  endfunction

  assign handoff = outValidQ && bus.out_ready;

  // Next-state and next-output logic for the expansion sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch can be inferred.
    stateD      = stateQ;
    capOpD      = capOp;
    capArgD     = capArg;
    capImmD     = capImm;
    capWideD    = capWide;
    outValidD   = outValidQ;
    outInstrD   = outInstrQ;
    prepModeD   = prepModeQ;
    errD        = 1'b0;
    instrCountD = instrCountQ;

    if (handoff) begin
      instrCountD = instrCountQ + CNT_W'(1);
    end

    unique case (stateQ)
      IDLE: begin
        if (bus.req_valid) begin
          capOpD   = bus.req_op;
          capArgD  = bus.req_arg;
          capImmD  = bus.req_imm;
          capWideD = bus.req_wide;
          if (isSingleOp(bus.req_op)) begin
            stateD    = OP;
            outValidD = 1'b1;
            outInstrD = opWord(bus.req_op, bus.req_arg);
          end else if (isPrepOp(bus.req_op)) begin
            stateD    = PREP;
            outValidD = 1'b1;
            // A wide immediate loads its upper half first; PSFT shifts it up.
            outInstrD = {DEC_PREP, bus.req_wide ? bus.req_imm[11:6] : bus.req_imm[5:0]};
          end else begin
            errD = 1'b1;
          end
        end
      end

      PREP: begin
        if (handoff) begin
          prepModeD = 1'b1;
          if (capWide) begin
            stateD    = PSFT;
            outInstrD = {DEC_PSFT, capImm[5:0]};
          end else begin
            stateD    = OP;
            outInstrD = opWord(capOp, capArg);
          end
        end
      end

      PSFT: begin
        if (handoff) begin
          stateD    = OP;
          outInstrD = opWord(capOp, capArg);
        end
      end

      OP: begin
        if (handoff) begin
          stateD    = IDLE;
          outValidD = 1'b0;
          // The decoder leaves prep mode once it consumes a prep-class op.
          if (isPrepOp(capOp)) begin
            prepModeD = 1'b0;
          end
        end
      end

      default: begin
        stateD    = IDLE;
        outValidD = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the design holds no memory arrays, so every register is cleared;
      // this guarantees a mid-request reset leaves no partial sequence behind.
      stateQ      <= IDLE;
      capOp       <= '0;
      capArg      <= '0;
      capImm      <= '0;
      capWide     <= 1'b0;
      outValidQ   <= 1'b0;
      outInstrQ   <= '0;
      prepModeQ   <= 1'b0;
      errQ        <= 1'b0;
      instrCountQ <= '0;
    end else begin
      stateQ      <= stateD;
      capOp       <= capOpD;
      capArg      <= capArgD;
      capImm      <= capImmD;
      capWide     <= capWideD;
      outValidQ   <= outValidD;
      outInstrQ   <= outInstrD;
      prepModeQ   <= prepModeD;
      errQ        <= errD;
      instrCountQ <= instrCountD;
    end
  end

  assign bus.req_ready   = (stateQ == IDLE);
  assign bus.out_valid   = outValidQ;
  assign bus.out_instr   = outInstrQ;
  assign bus.prep_mode   = prepModeQ;
  assign bus.err         = errQ;
  assign bus.instr_count = instrCountQ;

  // A stalled word stays presented and unchanged until it is consumed.
  assertStallHold: assert property (
    @(posedge clk) disable iff (reset)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_instr))
  );

  // Words are only presented while a request is being expanded.
  assertValidOnlyBusy: assert property (
    @(posedge clk) disable iff (reset)
    bus.out_valid |-> !bus.req_ready
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder.
// Requests are expanded into expected words by a behavioural model and queued;
// an independent monitor pops and compares on every word handoff and tracks
// the expected instruction count, prep mode and error pulses.
module tb_instr_encoder;

  localparam int TB_CNT_W = 4;

  typedef struct {
    logic [8:0] word;
    int         kind;   // 0 single op, 1 prep, 2 psft, 3 prep-class op
  } expT;

  logic clk;
  logic reset;

  instr_encoder_if #(.CNT_W(TB_CNT_W)) ifc ();

  instr_encoder #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;

  expT               expQ[$];
  logic [8:0]        seenQ[$];
  logic [TB_CNT_W-1:0] modelCount = '0;
  logic              modelPrep  = 1'b0;
  int                pendingErr = 0;
  int                readyMode  = 0;   // 0 always ready, 1 random, 2 three-cycle stall per word

  // Decoder opcode for each macro-op code (single-word ops 0-5, prep-class 6-10).
  logic [2:0] opcodeTable [11] = '{3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101,
                                   3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] seenAt(input int idx);
    logic [8:0] w;
    w = 'x;
    if (idx < seenQ.size()) w = seenQ[idx];
    return w;
  endfunction

  // Behavioural expansion of one accepted request into its expected words.
  function automatic void modelPush(input logic [3:0] op, input logic [5:0] arg,
                                    input logic [11:0] imm, input logic wide);
    expT e;
    int code;
    code = int'(op);
    if (code > 10) begin
      pendingErr++;
      return;
    end
    if (code >= 6) begin
      e.kind = 1;
      e.word = {3'b000, (wide ? imm[11:6] : imm[5:0])};
      expQ.push_back(e);
      if (wide) begin
        e.kind = 2;
        e.word = {3'b101, imm[5:0]};
        expQ.push_back(e);
      end
      e.kind = 3;
      e.word = {opcodeTable[code], arg};
    end else begin
      e.kind = 0;
      if (code == 0)      e.word = {opcodeTable[code], arg[5:1], 1'b1};
      else if (code == 1) e.word = {opcodeTable[code], arg[5:1], 1'b0};
      else                e.word = {opcodeTable[code], arg};
    end
    expQ.push_back(e);
  endfunction

  // Drives one request (called just after a rising edge); returns just after acceptance.
  task automatic issueReq(input logic [3:0] op, input logic [5:0] arg,
                          input logic [11:0] imm, input logic wide);
    int guard;
    guard = 0;
    while (!ifc.req_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ifc.req_ready) begin
      check("req_ready_timeout", 32'(ifc.req_ready), 32'd1);
      return;
    end
    ifc.req_valid = 1'b1;
    ifc.req_op    = op;
    ifc.req_arg   = arg;
    ifc.req_imm   = imm;
    ifc.req_wide  = wide;
    modelPush(op, arg, imm, wide);
    @(posedge clk); #1;
    // Scramble fields after acceptance; the encoder must have captured them.
    ifc.req_valid = 1'b0;
    ifc.req_op    = 4'($urandom);
    ifc.req_arg   = 6'($urandom);
    ifc.req_imm   = 12'($urandom);
    ifc.req_wide  = 1'($urandom);
  endtask

  // Waits until all expected words are consumed and the encoder is idle.
  task automatic drain();
    int guard;
    guard = 0;
    while ((expQ.size() != 0 || ifc.out_valid !== 1'b0 || ifc.req_ready !== 1'b1) && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_queue_empty", 32'(expQ.size()), 32'd0);
  endtask

  // Applies a one-cycle synchronous reset and clears the model.
  task automatic pulseReset();
    ifc.req_valid = 1'b0;
    reset = 1'b1;
    expQ.delete();
    modelCount = '0;
    modelPrep  = 1'b0;
    pendingErr = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Downstream readiness generator.
  initial begin : readyDriver
    int stallCnt;
    stallCnt = 0;
    ifc.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0: ifc.out_ready = 1'b1;
        1: ifc.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (ifc.out_valid !== 1'b1) begin
            stallCnt = 0;
            ifc.out_ready = 1'b0;
          end else if (stallCnt < 3) begin
            ifc.out_ready = 1'b0;
            stallCnt++;
          end else begin
            ifc.out_ready = 1'b1;
            stallCnt = 0;
          end
        end
      endcase
    end
  end

  // Monitor: compares every handoff against the scoreboard, sampling mid-cycle.
  initial begin : monitor
    expT        e;
    logic       prevStall;
    logic [8:0] prevInstr;
    prevStall = 1'b0;
    prevInstr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          check("stall_valid_held", 32'(ifc.out_valid), 32'd1);
          check("stall_instr_held", 32'(ifc.out_instr), 32'(prevInstr));
        end
        check("instr_count", 32'(ifc.instr_count), 32'(modelCount));
        check("prep_mode", 32'(ifc.prep_mode), 32'(modelPrep));
        if (ifc.err === 1'b1) begin
          check("err_expected", 32'(pendingErr > 0), 32'd1);
          if (pendingErr > 0) pendingErr--;
        end
        if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
          if (expQ.size() == 0) begin
            check("word_expected", 32'(expQ.size()), 32'd1);
          end else begin
            e = expQ.pop_front();
            check("out_instr", 32'(ifc.out_instr), 32'(e.word));
            seenQ.push_back(ifc.out_instr);
            modelCount++;
            if (e.kind == 1) modelPrep = 1'b1;
            else if (e.kind == 3) modelPrep = 1'b0;
          end
        end
        prevStall = (ifc.out_valid === 1'b1) && (ifc.out_ready !== 1'b1);
        prevInstr = ifc.out_instr;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [TB_CNT_W-1:0] cntBefore;
    reset         = 1'b1;
    ifc.req_valid = 1'b0;
    ifc.req_op    = '0;
    ifc.req_arg   = '0;
    ifc.req_imm   = '0;
    ifc.req_wide  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_out_instr", 32'(ifc.out_instr), 32'd0);
    check("rst_prep_mode", 32'(ifc.prep_mode), 32'd0);
    check("rst_err", 32'(ifc.err), 32'd0);
    check("rst_instr_count", 32'(ifc.instr_count), 32'd0);
    @(posedge clk); #1;

    // INC with immediate ready
    readyMode = 0;
    seenQ.delete();
    issueReq(4'd0, 6'b010110, 12'h000, 1'b0);
    drain();
    check("inc_words", 32'(seenQ.size()), 32'd1);
    check("inc_word0", 32'(seenAt(0)), 32'(9'b001_01011_1));
    check("inc_count", 32'(ifc.instr_count), 32'd1);
    check("inc_prep", 32'(ifc.prep_mode), 32'd0);

    // LW with narrow immediate
    seenQ.delete();
    issueReq(4'd8, 6'h05, 12'h02A, 1'b0);
    drain();
    check("lw_words", 32'(seenQ.size()), 32'd2);
    check("lw_word0", 32'(seenAt(0)), 32'(9'b000_101010));
    check("lw_word1", 32'(seenAt(1)), 32'(9'b010_000101));
    check("lw_prep_after", 32'(ifc.prep_mode), 32'd0);

    // ANDI with wide immediate, three stall cycles per word
    readyMode = 2;
    seenQ.delete();
    cntBefore = modelCount;
    issueReq(4'd6, 6'h33, 12'hABC, 1'b1);
    drain();
    readyMode = 0;
    check("andi_words", 32'(seenQ.size()), 32'd3);
    check("andi_word0", 32'(seenAt(0)), 32'(9'b000_101010));
    check("andi_word1", 32'(seenAt(1)), 32'(9'b101_111100));
    check("andi_word2", 32'(seenAt(2)), 32'(9'b000_110011));
    check("andi_count", 32'(ifc.instr_count), 32'(TB_CNT_W'(cntBefore + 3)));

    // Illegal op: one-cycle error, no words
    @(posedge clk); #1;
    seenQ.delete();
    cntBefore = modelCount;
    issueReq(4'd13, 6'h3F, 12'hFFF, 1'b1);
    check("ill_err_pulse", 32'(ifc.err), 32'd1);
    check("ill_ready", 32'(ifc.req_ready), 32'd1);
    check("ill_no_valid", 32'(ifc.out_valid), 32'd0);
    @(posedge clk); #1;
    check("ill_err_drop", 32'(ifc.err), 32'd0);
    check("ill_no_valid2", 32'(ifc.out_valid), 32'd0);
    check("ill_count", 32'(ifc.instr_count), 32'(cntBefore));
    check("ill_words", 32'(seenQ.size()), 32'd0);

    // Reset after the PREP handoff of a wide SW
    issueReq(4'd9, 6'h12, 12'h5A5, 1'b1);
    @(posedge clk); #1;
    check("sw_prep_set", 32'(ifc.prep_mode), 32'd1);
    pulseReset();
    @(negedge clk);
    check("mid_rst_valid", 32'(ifc.out_valid), 32'd0);
    check("mid_rst_prep", 32'(ifc.prep_mode), 32'd0);
    check("mid_rst_count", 32'(ifc.instr_count), 32'd0);
    check("mid_rst_ready", 32'(ifc.req_ready), 32'd1);
    @(posedge clk); #1;

    // Counter wrap: fifteen words to all-ones, one more to zero
    for (int i = 0; i < 15; i++) begin
      issueReq(4'd1, 6'($urandom), 12'h000, 1'b0);
    end
    drain();
    check("wrap_all_ones", 32'(ifc.instr_count), 32'hF);
    issueReq(4'd2, 6'h2A, 12'h000, 1'b0);
    drain();
    check("wrap_zero", 32'(ifc.instr_count), 32'd0);

    // Randomized traffic with random downstream readiness
    readyMode = 1;
    for (int i = 0; i < 200; i++) begin
      issueReq(4'($urandom_range(0, 15)), 6'($urandom), 12'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    readyMode = 0;
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(expQ.size()), 32'd0);
    check("final_err_balance", 32'(pendingErr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the emitted-instruction counter.
REQ-002 Port clk, input, 1, rising-edge clock.
REQ-003 Port reset, input, 1, synchronous, active-high reset.
REQ-004 Port req_valid, input, 1, macro-op request valid.
REQ-005 Port req_ready, output, 1, block can accept a request.
REQ-006 Port req_op, input, 4, macro-op code: 0 INC, 1 DEC, 2 XOR, 3 XORR, 4 SLL, 5 SRL, 6 ANDI, 7 BEQ, 8 LW, 9 SW, 10 SAVE, 11-15 illegal.
REQ-007 Port req_arg, input, 6, operand field; [5:1] register, [0] flag.
REQ-008 Port req_imm, input, 12, immediate for prep-class ops.
REQ-009 Port req_wide, input, 1, immediate needs 12 bits (PREP+PSFT) rather than 6 (PREP only).
REQ-010 Port out_valid, output, 1, out_instr holds a valid instruction word.
REQ-011 Port out_ready, input, 1, downstream decoder consumes the word.
REQ-012 Port out_instr, output, 9, instruction word {opcode[8:6], operand[5:0]}; bit 0 is the decoder lastBit.
REQ-013 Port prep_mode, output, 1, mirror of the decoder prep-enabled state as implied by words handed off so far.
REQ-014 Port err, output, 1, one-cycle pulse on acceptance of an illegal req_op.
REQ-015 Port instr_count, output, CNT_W, count of instruction words handed off.

Function
REQ-016 A request SHALL be accepted when req_valid and req_ready are both 1 on a rising edge; all req_* fields SHALL be captured then and ignored afterwards.
REQ-017 req_ready SHALL be 1 only in state IDLE; states are IDLE, PREP, PSFT, OP.
REQ-018 Single-word ops (codes 0-5) SHALL go IDLE->OP and emit: INC {001,arg[5:1],1}; DEC {001,arg[5:1],0}; XOR {010,arg}; XORR {011,arg}; SLL {100,arg}; SRL {101,arg}.
REQ-019 Prep-class ops (codes 6-10) with req_wide=0 SHALL go IDLE->PREP->OP, emitting {000,imm[5:0]} then the op word.
REQ-020 Prep-class ops with req_wide=1 SHALL go IDLE->PREP->PSFT->OP, emitting {000,imm[11:6]}, {101,imm[5:0]}, then the op word.
REQ-021 Prep-class op words: ANDI {000,arg}; BEQ {001,arg}; LW {010,arg}; SW {011,arg}; SAVE {100,arg}.
REQ-022 Illegal codes (11-15) SHALL be accepted, pulse err high for the cycle after acceptance, emit no word and stay in IDLE.
REQ-023 out_valid SHALL rise the cycle after entry to PREP, PSFT or OP; latency from acceptance to first out_valid is 1 cycle.
REQ-024 While out_valid=1 and out_ready=0, out_instr and state SHALL hold stable; no word is dropped or repeated.
REQ-025 A word is handed off when out_valid and out_ready are both 1; state SHALL then advance next edge, and out_valid SHALL be 1 in back-to-back words of one request with no bubble.
REQ-026 After handing off the OP word the block SHALL return to IDLE with out_valid=0; next request is accepted no earlier than the following edge (max throughput one single-word op per 2 cycles).
REQ-027 prep_mode SHALL set on handoff of a PREP word, stay set across PSFT handoff, and clear on handoff of a prep-class op word.
REQ-028 instr_count SHALL increment by 1 per handed-off word and wrap from all-ones to 0.
REQ-029 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-030 On reset: state IDLE, req_ready=1 on the following cycle, out_valid=0, out_instr=0, prep_mode=0, err=0, instr_count=0.
REQ-031 Reset mid-request SHALL discard the captured request and any pending word; no partial sequence resumes.

Verification
REQ-032 INC, arg=6'b010110, out_ready=1 -> one word 9'b001_01011_1, instr_count 0->1, prep_mode stays 0.
REQ-033 LW, arg=6'h05, imm=12'h02A, wide=0 -> words 9'b000_101010 then 9'b010_000101; prep_mode 1 between handoffs, 0 after.
REQ-034 ANDI, imm=12'hABC, wide=1, out_ready low 3 cycles per word -> words 000_101010, 101_111100, 000_arg each held stable while stalled; instr_count +3.
REQ-035 req_op=13 -> err pulse exactly 1 cycle, out_valid never 1, instr_count unchanged, req_ready=1 next cycle.
REQ-036 Reset asserted after PREP handoff of a wide SW -> next cycle out_valid=0, prep_mode=0, instr_count=0, state IDLE.
REQ-037 Preload instr_count to all-ones via 2^CNT_W-1 handoffs (or CNT_W=4 build: 15 words), one more word -> instr_count=0.
